wide_ram_responder: RTL and testbench
=====================================

Name: wide_ram_responder

Overview:
- Memory-side responder for the 128-bit SP RAM request/grant/rvalid interface that the L0 data cache drives as initiator.
- Holds a byte-addressed, line-organised 128-bit-wide store.
- Grants requests subject to an outstanding-request limit and an external stall.
- Returns exactly one in-order rvalid response per accepted request, reads and writes alike, after a fixed latency.
- Serves as the cache's backing memory in subsystem simulation and as the template for the real RAM controller.

Parameters:
- RAM_SIZE, 32768, store size in bytes; power of two, multiple of 16.
- DATA_WIDTH, 128, line width in bits; fixed at 128 for this block.
- LATENCY, 2, cycles from accepting edge to rvalid_o; legal range 1..8.
- MAX_OUTST, 2, maximum accepted-but-unanswered requests; legal range 1..8.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- en_i  in  1  request valid.
- addr_i  in  32  byte address; bits [3:0] ignored.
- wdata_i  in  128  write line data.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  16  write byte enables; bit k covers wdata_i[8k+7:8k].
- stall_i  in  1  forces gnt_o low (backpressure injection).
- gnt_o  out  1  request accepted this cycle when en_i && gnt_o.
- rvalid_o  out  1  one-cycle response pulse per accepted request.
- rdata_o  out  128  read data, qualified by rvalid_o.
- err_o  out  1  with rvalid_o: request address was out of range.

Behaviour:
- Reset (async assert, sync deassert handled by the top level):
  - rvalid_o=0, rdata_o=0, err_o=0, outstanding count=0, all pipeline valid bits cleared.
  - gnt_o is forced to 0 while rst=1.
  - Memory array is not reset.
  - Reset mid-operation drops all pending responses; no rvalid_o follows for requests accepted before reset.
- Grant (combinational): gnt_o = !rst && !stall_i && (cnt < MAX_OUTST || rvalid_o).
  - A response retiring in the same cycle frees its slot.
  - Full one-per-cycle throughput requires MAX_OUTST >= LATENCY.
- Accept: en_i && gnt_o at a rising edge.
- Index and range: index = addr_i[$clog2(RAM_SIZE)-1:4]; in-range when addr_i < RAM_SIZE.
- Write, in range: at the accepting edge, bytes with be_i[k]=1 are updated; the other bytes keep their value. be_i=0 is legal: no change, response still returned.
- Read: line captured at the accepting edge, after any write committed on an earlier edge.
  - A read accepted the cycle after a write to the same line returns the new data.
- Response pipeline: LATENCY stages; each stage holds {valid, is_read, err, data}.
  - Stage 0 loads at the accepting edge and the contents shift one stage per cycle unconditionally; the interface has no response backpressure.
  - rvalid_o is the last stage's valid bit; a request accepted at edge t gives rvalid_o high in cycle t+LATENCY.
- rdata_o:
  - Read response: the captured line.
  - Write response or error response: 128'h0.
  - Cycles with rvalid_o=0: rdata_o holds 0.
- Out of range (addr_i >= RAM_SIZE): request is still granted and answered in order. Write is suppressed; read returns 0. err_o=1 in its rvalid_o cycle, otherwise 0.
- Outstanding count: cnt += accept, cnt -= rvalid_o, both in the same cycle allowed. cnt never exceeds MAX_OUTST; exceeding it is an assertion failure.
- Signals are don't-care when en_i=0 or gnt_o=0. A request held while gnt_o=0 is accepted on the first cycle gnt_o=1.
- Ordering: responses are strictly in acceptance order; one rvalid_o per accept, no merging.

Test Plan:
- Write 0x0000_0010, wdata=128'h00112233_44556677_8899AABB_CCDDEEFF, be=16'hFFFF, then read 0x0000_0010 -> both gnt_o=1; rvalid_o exactly 2 cycles after each accept; the write response has rdata_o=0; the read returns the written line; err_o=0.
- After the line above, write 0x0000_0018 (same line) with wdata=all 0xA5, be=16'h000F, then read -> rdata_o=128'h00112233_44556677_8899AABB_A5A5A5A5.
- Four back-to-back reads of 0x00, 0x10, 0x20, 0x30 with en_i held high (LATENCY=2, MAX_OUTST=2) -> gnt_o high on all 4 cycles; rvalid_o high 4 consecutive cycles starting 2 cycles after the first accept; data in order.
- MAX_OUTST=1, LATENCY=3, en_i held high -> accepts spaced exactly 3 cycles apart, the next accept in each rvalid_o cycle; cnt never exceeds 1.
- stall_i=1 with en_i=1 for 5 cycles -> gnt_o=0 and no rvalid_o; stall_i drops -> accept that cycle, rvalid_o LATENCY cycles later.
- Read of 0x0000_8000 (RAM_SIZE=32768) -> rvalid_o=1, err_o=1, rdata_o=0; write to 0x0000_8000 followed by read of 0x0 -> line 0 unchanged.
- Reset asserted for 1 cycle with 2 reads outstanding -> rvalid_o, err_o and rdata_o go to 0 immediately; no rvalid_o for the dropped reads; gnt_o=1 the first cycle after deassert with en_i=1.

Source files
------------

// File: rtl/wide_ram_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : wide_ram_responder_if
//  Description : 128-bit SP RAM request/grant/rvalid bus between the L0 data
//                cache (master) and its backing memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface wide_ram_responder_if;
    logic         en_i;
    logic [31:0]  addr_i;
    logic [127:0] wdata_i;
    logic         we_i;
    logic [15:0]  be_i;
    logic         stall_i;
    logic         gnt_o;
    logic         rvalid_o;
    logic [127:0] rdata_o;
    logic         err_o;

    modport master (
        output en_i, addr_i, wdata_i, we_i, be_i, stall_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  en_i, addr_i, wdata_i, we_i, be_i, stall_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/wide_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : wide_ram_responder
//  Description : Line-organised 128-bit memory responder. Grants requests up
//                to an outstanding limit, returns one in-order response per
//                accepted request after a fixed pipeline latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_ram_responder #(
    parameter int RAM_SIZE   = 32768,
    parameter int DATA_WIDTH = 128,
    parameter int LATENCY    = 2,
    parameter int MAX_OUTST  = 2
) (
    input wire clk,
    input wire rst,
    wide_ram_responder_if.slave bus
);
    localparam int c_ADDR_W = $clog2(RAM_SIZE);
    localparam int c_IDX_W  = c_ADDR_W - 4;
    localparam int c_DEPTH  = RAM_SIZE / 16;
    localparam int c_BYTES  = DATA_WIDTH / 8;
    localparam int c_CNT_W  = $clog2(MAX_OUTST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT   = c_CNT_W'(MAX_OUTST);
    localparam logic [31:0]        c_RAM_LIMIT = 32'(RAM_SIZE);

    logic [DATA_WIDTH-1:0] r_mem  [c_DEPTH];

    // Response pipeline; stage LATENCY-1 drives the outputs. Read-vs-write
    // is resolved when stage 0 loads (writes load zero data), so no separate
    // is_read bit needs to travel down the pipe.
    logic                  r_vld  [LATENCY];
    logic                  r_err  [LATENCY];
    logic [DATA_WIDTH-1:0] r_data [LATENCY];

    logic [c_CNT_W-1:0]    r_cnt;

    logic                  w_gnt;
    logic                  w_accept;
    logic                  w_in_range;
    logic                  w_retire;
    logic [c_IDX_W-1:0]    w_idx;
    logic [DATA_WIDTH-1:0] w_rd_line;
    logic                  w_unused_addr;

    assign w_idx         = bus.addr_i[c_ADDR_W-1:4];
    assign w_unused_addr = ^bus.addr_i[3:0];
    assign w_in_range    = bus.addr_i < c_RAM_LIMIT;
    assign w_retire      = r_vld[LATENCY-1];

    // A response retiring this cycle frees its slot for a same-cycle grant.
    assign w_gnt    = !rst && !bus.stall_i && ((r_cnt < c_MAX_CNT) || w_retire);
    assign w_accept = bus.en_i && w_gnt;

    // Only in-range reads carry line data; writes and errors respond with 0.
    assign w_rd_line = (!bus.we_i && w_in_range) ? r_mem[w_idx] : '0;

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = r_vld[LATENCY-1];
    assign bus.rdata_o  = r_data[LATENCY-1];
    assign bus.err_o    = r_err[LATENCY-1];

    // Byte-enabled line write at the accepting edge; the array has no reset.
    always_ff @(posedge clk) begin
        if (w_accept && bus.we_i && w_in_range) begin
            for (int k = 0; k < c_BYTES; k++) begin
                if (bus.be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Response pipe: stage 0 loads every edge, all stages shift unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_vld[s]  <= 1'b0;
                r_err[s]  <= 1'b0;
                r_data[s] <= '0;
            end
        end else begin
            r_vld[0]  <= w_accept;
            r_err[0]  <= w_accept && !w_in_range;
            r_data[0] <= w_accept ? w_rd_line : '0;
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_err[s]  <= r_err[s-1];
                r_data[s] <= r_data[s-1];
            end
        end
    end

    // Outstanding count: +1 per accept, -1 per retiring response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(w_accept) - c_CNT_W'(w_retire);
        end
    end

    // The grant rule must keep the outstanding count within its limit.
    a_cnt_bound: assert property (@(posedge clk) disable iff (rst) r_cnt <= c_MAX_CNT);

endmodule
`default_nettype wire

// File: tb/tb_wide_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_ram_responder
//  Description : Bench for wide_ram_responder. Two instances (LATENCY/MAX_OUTST
//                2/2 and 3/1) share one stimulus stream and are compared each
//                cycle against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_ram_responder;

    typedef struct {
        int           due;
        logic [127:0] data;
        logic         err;
        bit           known;
    } resp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic         we;
    logic [15:0]  be;
    logic         stall;

    logic         gnt_w    [2];
    logic         rvalid_w [2];
    logic [127:0] rdata_w  [2];
    logic         err_w    [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int max_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Preload pattern for line i.
    function automatic logic [127:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {4{b ^ 8'h3C, 8'h96, b, 8'h69}};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        wide_ram_responder_if bus ();
        assign bus.en_i    = en;
        assign bus.addr_i  = addr;
        assign bus.wdata_i = wdata;
        assign bus.we_i    = we;
        assign bus.be_i    = be;
        assign bus.stall_i = stall;

        wide_ram_responder #(
            .RAM_SIZE  (32768),
            .DATA_WIDTH(128),
            .LATENCY   ((g == 0) ? 2 : 3),
            .MAX_OUTST ((g == 0) ? 2 : 1)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );

        assign gnt_w[g]    = bus.gnt_o;
        assign rvalid_w[g] = bus.rvalid_o;
        assign rdata_w[g]  = bus.rdata_o;
        assign err_w[g]    = bus.err_o;
    end

    // ------------------------------------------------------------------
    // Reference model and per-cycle compare (both instances).
    // ------------------------------------------------------------------
    resp_t      q     [2][$];
    bit [127:0] mem   [2][2048];
    bit         known [2][2048];

    initial begin : compare
        resp_t      r;
        logic       ev;
        logic       eg;
        logic       inr;
        logic [10:0] idx;
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    q[i].delete();
                    check($sformatf("u%0d_rst_gnt", i), gnt_w[i], 1'b0);
                    check($sformatf("u%0d_rst_rvalid", i), rvalid_w[i], 1'b0);
                    check($sformatf("u%0d_rst_rdata", i), rdata_w[i], 128'h0);
                    check($sformatf("u%0d_rst_err", i), err_w[i], 1'b0);
                end else begin
                    ev = (q[i].size() > 0) && (q[i][0].due == cyc);
                    eg = !stall && ((q[i].size() < max_of(i)) || ev);
                    check($sformatf("u%0d_gnt", i), gnt_w[i], eg);
                    check($sformatf("u%0d_rvalid", i), rvalid_w[i], ev);
                    if (ev) begin
                        r = q[i].pop_front();
                        check($sformatf("u%0d_err", i), err_w[i], r.err);
                        if (r.known) check($sformatf("u%0d_rdata", i), rdata_w[i], r.data);
                    end else begin
                        check($sformatf("u%0d_idle_rdata", i), rdata_w[i], 128'h0);
                        check($sformatf("u%0d_idle_err", i), err_w[i], 1'b0);
                    end
                    if (en && eg) begin
                        inr     = addr < 32'h8000;
                        idx     = addr[14:4];
                        r.due   = cyc + lat_of(i);
                        r.err   = !inr;
                        r.data  = '0;
                        r.known = 1'b1;
                        if (inr && we) begin
                            for (int k = 0; k < 16; k++)
                                if (be[k]) mem[i][idx][8*k +: 8] = wdata[8*k +: 8];
                            if (be == 16'hFFFF) known[i][idx] = 1'b1;
                        end else if (inr) begin
                            r.data  = mem[i][idx];
                            r.known = known[i][idx];
                        end
                        q[i].push_back(r);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (timed against instance 0).
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a request and wait for instance 0 to take it; returns at the
    // start of the cycle after the accept.
    task automatic issue(input logic w, input logic [31:0] a, input logic [127:0] d,
                         input logic [15:0] b, input bit hold, output int waited);
        bit ok;
        ok     = 1'b0;
        waited = 0;
        en = 1'b1; we = w; addr = a; wdata = d; be = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (gnt_w[0]) ok = 1'b1;
            else waited++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got no grant expected grant within 50 cycles");
        end
        if (!hold) en = 1'b0;
    endtask

    // Literal check of instance 0's response, due two cycles after the accept.
    task automatic expect_resp(input string nm, input logic [127:0] d, input logic e);
        @(negedge clk);
        check({nm, "_early"}, rvalid_w[0], 1'b0);
        @(negedge clk);
        check({nm, "_rv"}, rvalid_w[0], 1'b1);
        check({nm, "_data"}, rdata_w[0], d);
        check({nm, "_err"}, err_w[0], e);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int w;
        int nacc;
        int acc [4];
        int r;
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; stall = 1'b0;
        @(negedge clk);
        check("reset_gnt", gnt_w[0], 1'b0);
        check("reset_rvalid", rvalid_w[0], 1'b0);
        check("reset_rdata", rdata_w[0], 128'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Preload lines 0..15 back to back.
        for (int i = 0; i < 16; i++)
            issue(1'b1, 32'(i << 4), pat(i), 16'hFFFF, (i != 15), w);
        idle(4);

        // Full-line write then read back.
        issue(1'b1, 32'h10, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 1'b0, w);
        expect_resp("wr_full", 128'h0, 1'b0);
        issue(1'b0, 32'h10, '0, '0, 1'b0, w);
        expect_resp("rd_full", 128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);

        // Partial write (low four bytes) to the same line.
        issue(1'b1, 32'h18, {16{8'hA5}}, 16'h000F, 1'b0, w);
        expect_resp("wr_part", 128'h0, 1'b0);
        issue(1'b0, 32'h18, '0, '0, 1'b0, w);
        expect_resp("rd_part", 128'h00112233_44556677_8899AABB_A5A5A5A5, 1'b0);
        idle(4);

        // Four back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 32'(i * 16), '0, '0, (i != 3), w);
            check($sformatf("b2b_wait%0d", i), 32'(w), 32'd0);
        end
        @(negedge clk);
        check("b2b_rv2", rvalid_w[0], 1'b1);
        check("b2b_data2", rdata_w[0], 128'h3E960269_3E960269_3E960269_3E960269);
        @(negedge clk);
        check("b2b_rv3", rvalid_w[0], 1'b1);
        check("b2b_data3", rdata_w[0], 128'h3F960369_3F960369_3F960369_3F960369);
        @(posedge clk); #1;
        idle(5);

        // Request held high: instance 1 (MAX_OUTST=1, LATENCY=3) every 3 cycles.
        en = 1'b1; we = 1'b0; addr = 32'h30;
        nacc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (gnt_w[1]) begin
                if (nacc < 4) acc[nacc] = k;
                nacc++;
            end
            check($sformatf("hold_gnt0_%0d", k), gnt_w[0], 1'b1);
            @(posedge clk); #1;
        end
        en = 1'b0;
        check("m1_accept_count", 32'(nacc), 32'd4);
        for (int j = 0; j < 4; j++)
            if (j < nacc) check($sformatf("m1_accept_cycle%0d", j), 32'(acc[j]), 32'(3 * j));
        idle(5);

        // Stall for five cycles with a pending request.
        stall = 1'b1; en = 1'b1; we = 1'b0; addr = 32'h20;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_gnt%0d", k), gnt_w[0], 1'b0);
            check($sformatf("stall_rv%0d", k), rvalid_w[0], 1'b0);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_gnt", gnt_w[0], 1'b1);
        @(posedge clk); #1;
        en = 1'b0;
        expect_resp("unstall", 128'h3E960269_3E960269_3E960269_3E960269, 1'b0);
        idle(4);

        // Out-of-range read and write; line 0 must be untouched.
        issue(1'b0, 32'h8000, '0, '0, 1'b0, w);
        expect_resp("oor_rd", 128'h0, 1'b1);
        issue(1'b1, 32'h8000, {128{1'b1}}, 16'hFFFF, 1'b0, w);
        expect_resp("oor_wr", 128'h0, 1'b1);
        issue(1'b0, 32'h0, '0, '0, 1'b0, w);
        expect_resp("line0", 128'h3C960069_3C960069_3C960069_3C960069, 1'b0);
        idle(4);

        // Reset with two reads outstanding.
        issue(1'b0, 32'h20, '0, '0, 1'b1, w);
        issue(1'b0, 32'h30, '0, '0, 1'b0, w);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rv", rvalid_w[0], 1'b0);
        check("midrst_rdata", rdata_w[0], 128'h0);
        check("midrst_err", err_w[0], 1'b0);
        check("midrst_gnt", gnt_w[0], 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1; we = 1'b0; addr = 32'h0;
        @(negedge clk);
        check("postrst_gnt", gnt_w[0], 1'b1);
        check("postrst_rv0", rvalid_w[0], 1'b0);
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        check("postrst_rv1", rvalid_w[0], 1'b0);
        @(negedge clk);
        check("postrst_rv2", rvalid_w[0], 1'b1);
        check("postrst_data", rdata_w[0], 128'h3C960069_3C960069_3C960069_3C960069);
        @(posedge clk); #1;
        idle(4);

        // Randomised traffic; the model checks every cycle.
        for (int n = 0; n < 1500; n++) begin
            en    = ($urandom % 4) != 0;
            we    = ($urandom % 2) != 0;
            stall = ($urandom % 5) == 0;
            r     = int'($urandom % 10);
            if (r == 0)      addr = 32'h8000 + ($urandom % 64);
            else if (r == 1) addr = 32'hFFFF_FFF0 | ($urandom % 16);
            else             addr = {24'h0, 4'($urandom % 16), 4'($urandom % 16)};
            wdata = {$urandom, $urandom, $urandom, $urandom};
            be    = (($urandom % 8) == 0) ? 16'h0 : 16'($urandom);
            rst   = ($urandom % 300) == 0;
            @(posedge clk); #1;
        end
        rst = 1'b0; stall = 1'b0;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
